// File: rtl/mtl2_key_debounce.sv
// mtl2_key_debounce: 2-flop synchronizer and per-key debounce counters.
// Produces registered clean levels plus one-cycle press/release pulses.
module mtl2_key_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_clean,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release,
    output logic [WIDTH-1:0] key_busy
);

    localparam logic [WIDTH-1:0] IDLE = {WIDTH{ACTIVE_LOW}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX =
        CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    logic [WIDTH-1:0][CNT_WIDTH-1:0] cnt;
    logic [WIDTH-1:0][CNT_WIDTH-1:0] cnt_nxt;

    logic [WIDTH-1:0] clean_nxt;
    logic [WIDTH-1:0] press_nxt;
    logic [WIDTH-1:0] release_nxt;
    logic [WIDTH-1:0] busy_nxt;

    // Any sample equal to the clean level aborts the window and restarts it.
    always_comb begin
        cnt_nxt     = '0;
        clean_nxt   = key_clean;
        press_nxt   = '0;
        release_nxt = '0;
        busy_nxt    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] != key_clean[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    clean_nxt[i] = sync2[i];
                    if (sync2[i] == ACTIVE_LOW) begin
                        release_nxt[i] = 1'b1;
                    end else begin
                        press_nxt[i] = 1'b1;
                    end
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
                end
            end
            busy_nxt[i] = (cnt_nxt[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1       <= IDLE;
            sync2       <= IDLE;
            cnt         <= '0;
            key_clean   <= IDLE;
            key_press   <= '0;
            key_release <= '0;
            key_busy    <= '0;
        end else begin
            sync1       <= key_raw;
            sync2       <= sync1;
            cnt         <= cnt_nxt;
            key_clean   <= clean_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
            key_busy    <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_mtl2_key_debounce.sv
// tb_mtl2_key_debounce: cycle-exact vector table plus directed sequences
// for simultaneous release and reset during an open debounce window.
module tb_mtl2_key_debounce;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key_raw = 4'h0;
    logic [3:0] key_clean;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    mtl2_key_debounce #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH      (3),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_raw    (key_raw),
        .key_clean  (key_clean),
        .key_press  (key_press),
        .key_release(key_release),
        .key_busy   (key_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] raw;
        logic [3:0] clean;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] busy;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic [3:0] raw,
                       input logic [3:0] c, input logic [3:0] p,
                       input logic [3:0] rl, input logic [3:0] b);
        vec_t v;
        v.rst = r; v.raw = raw; v.clean = c;
        v.press = p; v.rel = rl; v.busy = b;
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs edges until any pulse appears; n = -1 when the budget expires.
    task automatic wait_pulse(input int lim, output int n,
                              output logic [3:0] p, output logic [3:0] r,
                              output logic [3:0] c);
        n = 0; p = '0; r = '0; c = '0;
        for (int k = 0; k < lim; k++) begin
            step();
            n++;
            if ((key_press | key_release) != 4'h0) begin
                p = key_press; r = key_release; c = key_clean;
                return;
            end
        end
        n = -1;
    endtask

    initial begin
        int         n;
        logic [3:0] p, r, c;

        // reset held with raw all-pressed
        for (int k = 0; k < 3; k++) add(1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        add(0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        add(0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        add(0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF);
        add(0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF);
        add(0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF);
        add(0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0);
        // all keys released
        add(0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        add(0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        add(0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF);
        add(0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF);
        add(0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF);
        add(0, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0);
        add(0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
        // clean press of key0
        add(0, 4'hE, 4'hF, 4'h0, 4'h0, 4'h0);
        add(0, 4'hE, 4'hF, 4'h0, 4'h0, 4'h0);
        add(0, 4'hE, 4'hF, 4'h0, 4'h0, 4'h1);
        add(0, 4'hE, 4'hF, 4'h0, 4'h0, 4'h1);
        add(0, 4'hE, 4'hF, 4'h0, 4'h0, 4'h1);
        add(0, 4'hE, 4'hE, 4'h1, 4'h0, 4'h0);
        add(0, 4'hE, 4'hE, 4'h0, 4'h0, 4'h0);
        // key0 release
        add(0, 4'hF, 4'hE, 4'h0, 4'h0, 4'h0);
        add(0, 4'hF, 4'hE, 4'h0, 4'h0, 4'h0);
        add(0, 4'hF, 4'hE, 4'h0, 4'h0, 4'h1);
        add(0, 4'hF, 4'hE, 4'h0, 4'h0, 4'h1);
        add(0, 4'hF, 4'hE, 4'h0, 4'h0, 4'h1);
        add(0, 4'hF, 4'hF, 4'h0, 4'h1, 4'h0);
        add(0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
        // bouncing key1: low 2, high 1, then low
        add(0, 4'hD, 4'hF, 4'h0, 4'h0, 4'h0);
        add(0, 4'hD, 4'hF, 4'h0, 4'h0, 4'h0);
        add(0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h2);
        add(0, 4'hD, 4'hF, 4'h0, 4'h0, 4'h2);
        add(0, 4'hD, 4'hF, 4'h0, 4'h0, 4'h0);
        add(0, 4'hD, 4'hF, 4'h0, 4'h0, 4'h2);
        add(0, 4'hD, 4'hF, 4'h0, 4'h0, 4'h2);
        add(0, 4'hD, 4'hF, 4'h0, 4'h0, 4'h2);
        add(0, 4'hD, 4'hD, 4'h2, 4'h0, 4'h0);
        add(0, 4'hD, 4'hD, 4'h0, 4'h0, 4'h0);
        // key1 release
        add(0, 4'hF, 4'hD, 4'h0, 4'h0, 4'h0);
        add(0, 4'hF, 4'hD, 4'h0, 4'h0, 4'h0);
        add(0, 4'hF, 4'hD, 4'h0, 4'h0, 4'h2);
        add(0, 4'hF, 4'hD, 4'h0, 4'h0, 4'h2);
        add(0, 4'hF, 4'hD, 4'h0, 4'h0, 4'h2);
        add(0, 4'hF, 4'hF, 4'h0, 4'h2, 4'h0);
        add(0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
        // 3-cycle glitch on key2 is rejected
        add(0, 4'hB, 4'hF, 4'h0, 4'h0, 4'h0);
        add(0, 4'hB, 4'hF, 4'h0, 4'h0, 4'h0);
        add(0, 4'hB, 4'hF, 4'h0, 4'h0, 4'h4);
        add(0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h4);
        add(0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h4);
        add(0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
        add(0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
        add(0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);

        for (int i = 0; i < tv.size(); i++) begin
            reset   = tv[i].rst;
            key_raw = tv[i].raw;
            step();
            chk($sformatf("v%0d clean", i), 32'(key_clean), 32'(tv[i].clean));
            chk($sformatf("v%0d press", i), 32'(key_press), 32'(tv[i].press));
            chk($sformatf("v%0d release", i), 32'(key_release), 32'(tv[i].rel));
            chk($sformatf("v%0d busy", i), 32'(key_busy), 32'(tv[i].busy));
        end

        // keys 0 and 3 pressed together, then released together
        key_raw = 4'h6;
        wait_pulse(20, n, p, r, c);
        chk("sim_press latency", 32'(n), 32'd6);
        chk("sim_press press", 32'(p), 32'h9);
        chk("sim_press release", 32'(r), 32'h0);
        chk("sim_press clean", 32'(c), 32'h6);
        key_raw = 4'hF;
        wait_pulse(20, n, p, r, c);
        chk("sim_rel latency", 32'(n), 32'd6);
        chk("sim_rel release", 32'(r), 32'h9);
        chk("sim_rel press", 32'(p), 32'h0);
        chk("sim_rel clean", 32'(c), 32'hF);
        step();
        chk("sim_rel single cycle", 32'(key_release), 32'h0);
        repeat (2) step();

        // reset while key0 window is at count 2
        key_raw = 4'hE;
        repeat (4) step();
        chk("midrst busy before", 32'(key_busy), 32'h1);
        reset = 1'b1;
        step();
        chk("midrst clean", 32'(key_clean), 32'hF);
        chk("midrst busy", 32'(key_busy), 32'h0);
        chk("midrst pulses", 32'(key_press | key_release), 32'h0);
        reset = 1'b0;
        wait_pulse(20, n, p, r, c);
        chk("midrst latency", 32'(n), 32'd6);
        chk("midrst press", 32'(p), 32'h1);
        chk("midrst clean after", 32'(c), 32'hE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mtl2_key_debounce.md
Name: mtl2_key_debounce

Overview:
Conditions the raw push-button inputs of the MTL2 painter board before they reach the key PIO's `in_port`. It applies a 2-flop synchronizer and an independent per-key debounce counter to each button. `key_clean` connects directly to the PIO input, so the PIO's falling-edge capture sees exactly one edge per physical press. It also provides registered one-cycle press/release pulses for local fabric logic.

Parameters:
- WIDTH, 4, number of keys.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level (20 ms at 50 MHz). Legal range is at least 1.
- CNT_WIDTH, 20, counter width. Must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES-1.
- ACTIVE_LOW, 1, 1 = keys read 0 when pressed and idle high. 0 = active-high keys.

Ports:
- clk, input, 1, single system clock.
- reset, input, 1, synchronous, active-high.
- key_raw, input, WIDTH, asynchronous raw button levels.
- key_clean, output, WIDTH, debounced level, registered. Feeds PIO `in_port`.
- key_press, output, WIDTH, one-cycle pulse per key on an accepted idle→active transition.
- key_release, output, WIDTH, one-cycle pulse per key on an accepted active→idle transition.
- key_busy, output, WIDTH, per key: 1 while that key's counter is non-zero.

Behaviour:
- IDLE denotes {WIDTH{ACTIVE_LOW[0]}}.
- Reset (sampled on the clk rising edge):
  - sync1, sync2 and key_clean load IDLE.
  - All counters load 0.
  - key_press, key_release and key_busy load 0.
  - Reset asserted mid-count discards the count. No pulse is generated on reset, including when key_clean was not IDLE before reset.
- Synchronizer: sync1 <= key_raw and sync2 <= sync1 every cycle. Only sync2 is used downstream.
- Per key i, two states: STABLE (cnt==0) and CHANGING (cnt!=0). On each rising edge:
  - If sync2[i] == key_clean[i]: cnt <= 0. A glitch shorter than the window aborts and restarts.
  - Else if cnt == DEBOUNCE_CYCLES-1: key_clean[i] <= sync2[i] and cnt <= 0. Pulse key_press[i] if the new level is active, or key_release[i] if it is idle.
  - Else: cnt <= cnt+1.
- Pulses are registered and high for exactly the one cycle in which key_clean[i] first shows the new value. They are otherwise 0.
- Latency: a raw change that is stable and meets setup before rising edge E appears on key_clean at edge E+DEBOUNCE_CYCLES+1. This is DEBOUNCE_CYCLES+2 edges counting E.
- Keys are fully independent. Simultaneous transitions on several keys each produce their own pulse in the same cycle.
- Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- key_busy[i] is a registered reflection of cnt!=0.
- DEBOUNCE_CYCLES==1: cnt is always 0, and key_clean follows sync2 with one extra register stage.
- Raw change after acceptance: if the raw level returns to the previous value, a new full window is required to revert.
- Clean-output guarantee: key_clean can toggle at most once per DEBOUNCE_CYCLES cycles per key.

Test Plan:
1. Reset check (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1): hold reset for 3 cycles with key_raw=4'b0000.
   - During reset: key_clean=4'b1111 and all pulses 0.
   - After release, with key_raw held at 0000: key_clean[3:0] → 0000 exactly 6 edges later, with key_press=4'b1111 for 1 cycle.
2. Clean press, key0 (key_raw 1111→1110 before edge E):
   - key_clean=1110 first at edge E+5.
   - key_press=0001 for 1 cycle.
   - key_busy[0] high for 3 cycles before acceptance.
3. Bounce on key1: toggle key_raw[1] low 2 cycles, high 1 cycle, low 2 cycles, then hold low.
   - key_clean[1] changes exactly once, 6 edges after the final low begins.
   - Exactly one key_press[1] pulse.
4. Glitch rejection: key_raw[2] low for 3 cycles (< window+sync), then high.
   - key_clean stays 1111 and no pulses.
   - key_busy[2] returns to 0.
5. Simultaneous release: keys 0 and 3 pressed and accepted, then both key_raw bits return to 1 at the same edge.
   - key_release=1001 in a single cycle.
   - key_clean=1111.
6. Reset mid-count: assert reset when key0's cnt==2.
   - key_clean=1111, cnt=0, no pulse.
   - After release with key_raw[0] still low: a full 6-edge latency is needed before key_press[0].
